// File: rtl/ex_mem_skid_stage_pkg.sv
// Shared EX/MEM definitions: control-bundle bit positions, payload sizing
// and the redirect decision used by the skid stage.
package ex_mem_skid_stage_pkg;

    // Bit positions inside the {mem_to_reg, mem_write, mem_read, reg_write} bundle
    localparam int kSAIL_EXMEM_CTRL_REGWRITE = 0;
    localparam int kSAIL_EXMEM_CTRL_MEMREAD  = 1;
    localparam int kSAIL_EXMEM_CTRL_MEMWRITE = 2;
    localparam int kSAIL_EXMEM_CTRL_MEMTOREG = 3;

    // Payload held per slot: {alu_out, store_data, rd, ctrl}
    function automatic int exmem_payload_width(input int data_w, input int rd_w, input int ctrl_w);
        return 2 * data_w + rd_w + ctrl_w;
    endfunction

    localparam int kSAIL_EXMEM_PAYLOAD_WIDTH = exmem_payload_width(32, 5, 4);

    // Jumps always redirect; conditional branches only when the ALU says taken
    function automatic logic exmem_is_redirect(input logic is_jump, input logic is_branch,
                                               input logic branch_enable);
        return is_jump | (is_branch & branch_enable);
    endfunction

endpackage

// File: rtl/ex_mem_entry_reg.sv
// One buffer slot: a valid bit that is rewritten every cycle plus a payload
// register that only changes when load is asserted.
module ex_mem_entry_reg #(
    parameter int WIDTH = 73
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_d,
    input  logic             load,
    input  logic [WIDTH-1:0] data_d,
    output logic             valid_q,
    output logic [WIDTH-1:0] data_q
);

    // Valid follows valid_d each cycle; payload is captured only on load
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            if (load) begin
                data_q <= data_d;
            end
        end
    end

endmodule

// File: rtl/ex_mem_skid_stage.sv
// EX/MEM boundary: two-entry skid buffer (out slot + skid slot) with a
// registered PC redirect for taken branches and jumps. The input arriving
// while the redirect is visible is on the wrong path and is dropped.
module ex_mem_skid_stage
    import ex_mem_skid_stage_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int RD_WIDTH   = 5,
    parameter int CTRL_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_alu_out,
    input  logic                  in_branch_enable,
    input  logic                  in_is_branch,
    input  logic                  in_is_jump,
    input  logic [DATA_WIDTH-1:0] in_branch_target,
    input  logic [DATA_WIDTH-1:0] in_store_data,
    input  logic [RD_WIDTH-1:0]   in_rd,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_alu_out,
    output logic [DATA_WIDTH-1:0] out_store_data,
    output logic [RD_WIDTH-1:0]   out_rd,
    output logic [CTRL_WIDTH-1:0] out_ctrl,
    output logic                  redirect_valid,
    output logic [DATA_WIDTH-1:0] redirect_pc
);

    localparam int PW = exmem_payload_width(DATA_WIDTH, RD_WIDTH, CTRL_WIDTH);

    logic [PW-1:0] in_payload;
    logic [PW-1:0] out_payload;
    logic [PW-1:0] out_data_d;
    logic [PW-1:0] skid_payload;
    logic          skid_valid;
    logic          out_valid_d;
    logic          out_load;
    logic          skid_valid_d;
    logic          skid_load;
    logic          squash;
    logic          accept;
    logic          drain;
    logic          redirect_hit;

    assign in_payload = {in_alu_out, in_store_data, in_rd, in_ctrl};

    // in_ready depends only on held state, never on out_ready
    assign in_ready     = ~skid_valid;
    assign squash       = redirect_valid;
    assign accept       = in_valid & in_ready & ~flush & ~squash;
    assign drain        = ~out_valid | out_ready;
    assign redirect_hit = accept & exmem_is_redirect(in_is_jump, in_is_branch, in_branch_enable);

    // Slot steering: skid refills the out slot first, otherwise input goes
    // straight to out, or parks in skid when the out slot is stalled
    always_comb begin
        out_valid_d  = out_valid;
        out_load     = 1'b0;
        out_data_d   = in_payload;
        skid_valid_d = skid_valid;
        skid_load    = 1'b0;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (drain) begin
            if (skid_valid) begin
                out_load     = 1'b1;
                out_data_d   = skid_payload;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_load    = 1'b1;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_load    = 1'b1;
            skid_valid_d = 1'b1;
        end
    end

    ex_mem_entry_reg #(.WIDTH(PW)) u_out_slot (
        .clk     (clk),
        .reset   (reset),
        .valid_d (out_valid_d),
        .load    (out_load),
        .data_d  (out_data_d),
        .valid_q (out_valid),
        .data_q  (out_payload)
    );

    ex_mem_entry_reg #(.WIDTH(PW)) u_skid_slot (
        .clk     (clk),
        .reset   (reset),
        .valid_d (skid_valid_d),
        .load    (skid_load),
        .data_d  (in_payload),
        .valid_q (skid_valid),
        .data_q  (skid_payload)
    );

    assign {out_alu_out, out_store_data, out_rd, out_ctrl} = out_payload;

    // One-cycle redirect pulse; accept already excludes flush and squash,
    // so a redirect can never follow a redirect
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            redirect_valid <= redirect_hit;
            if (redirect_hit) begin
                redirect_pc <= in_branch_target;
            end
        end
    end

endmodule

// File: tb/tb_ex_mem_skid_stage.sv
// Bench for ex_mem_skid_stage: directed scenarios followed by random traffic,
// all checked against a queue-based model of a two-deep pipeline buffer.
module tb_ex_mem_skid_stage;
    import ex_mem_skid_stage_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready;
    logic [31:0] in_alu_out, in_branch_target, in_store_data;
    logic        in_branch_enable, in_is_branch, in_is_jump;
    logic [4:0]  in_rd;
    logic [3:0]  in_ctrl;
    logic        flush;
    logic        out_valid, out_ready;
    logic [31:0] out_alu_out, out_store_data;
    logic [4:0]  out_rd;
    logic [3:0]  out_ctrl;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] sd;
        logic [4:0]  rd;
        logic [3:0]  ctrl;
    } ent_t;

    ent_t        q[$];
    logic        redir;
    logic [31:0] redir_pc;
    int          tests_run = 0;
    int          tests_failed = 0;

    always #5 clk = ~clk;

    ex_mem_skid_stage dut (
        .clk              (clk),
        .reset            (reset),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_alu_out       (in_alu_out),
        .in_branch_enable (in_branch_enable),
        .in_is_branch     (in_is_branch),
        .in_is_jump       (in_is_jump),
        .in_branch_target (in_branch_target),
        .in_store_data    (in_store_data),
        .in_rd            (in_rd),
        .in_ctrl          (in_ctrl),
        .flush            (flush),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_alu_out      (out_alu_out),
        .out_store_data   (out_store_data),
        .out_rd           (out_rd),
        .out_ctrl         (out_ctrl),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc)
    );

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] alu, input logic br, input logic en,
                         input logic j, input logic [31:0] tgt, input logic [4:0] rd,
                         input logic [3:0] ctrl);
        in_valid         = v;
        in_alu_out       = alu;
        in_store_data    = alu ^ 32'h5A5A_0000;
        in_is_branch     = br;
        in_branch_enable = en;
        in_is_jump       = j;
        in_branch_target = tgt;
        in_rd            = rd;
        in_ctrl          = ctrl;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0, 4'd0);
    endtask

    task automatic check_model();
        chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
        chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
        chk("redirect_valid", 32'(redirect_valid), 32'(redir));
        if (redir) chk("redirect_pc", redirect_pc, redir_pc);
        if (q.size() > 0) begin
            chk("out_alu_out", out_alu_out, q[0].alu);
            chk("out_store_data", out_store_data, q[0].sd);
            chk("out_rd", 32'(out_rd), 32'(q[0].rd));
            chk("out_ctrl", 32'(out_ctrl), 32'(q[0].ctrl));
        end
    endtask

    // Model: a two-deep FIFO; the wrong-path input is dropped while a redirect shows
    task automatic cycle();
        logic acc;
        logic pop;
        ent_t e;
        @(posedge clk);
        acc = in_valid && (q.size() < 2) && !flush && !redir;
        pop = (q.size() > 0) && out_ready;
        if (flush) begin
            q.delete();
            redir = 1'b0;
        end else begin
            if (pop) void'(q.pop_front());
            if (acc) begin
                e.alu  = in_alu_out;
                e.sd   = in_store_data;
                e.rd   = in_rd;
                e.ctrl = in_ctrl;
                q.push_back(e);
            end
            redir = acc && (in_is_jump || (in_is_branch && in_branch_enable));
            if (redir) redir_pc = in_branch_target;
        end
        @(negedge clk);
        check_model();
    endtask

    localparam logic [3:0] kCTRL_RW = 4'(1 << kSAIL_EXMEM_CTRL_REGWRITE);

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b0;
        redir     = 1'b0;
        redir_pc  = 32'h0;
        idle();
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_redirect_valid", 32'(redirect_valid), 32'd0);
        chk("rst_out_alu_out", out_alu_out, 32'd0);
        chk("rst_redirect_pc", redirect_pc, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Streaming
        out_ready = 1'b1;
        drive(1'b1, 32'h11, 1'b0, 1'b0, 1'b0, 32'h0, 5'd2, kCTRL_RW); cycle();
        chk("stream_0x11", out_alu_out, 32'h11);
        chk("stream_ready0", 32'(in_ready), 32'd1);
        drive(1'b1, 32'h22, 1'b0, 1'b0, 1'b0, 32'h0, 5'd3, kCTRL_RW); cycle();
        chk("stream_0x22", out_alu_out, 32'h22);
        drive(1'b1, 32'h33, 1'b0, 1'b0, 1'b0, 32'h0, 5'd4, kCTRL_RW); cycle();
        chk("stream_0x33", out_alu_out, 32'h33);
        chk("stream_ready2", 32'(in_ready), 32'd1);
        idle(); cycle();

        // Backpressure
        out_ready = 1'b0;
        drive(1'b1, 32'hA, 1'b0, 1'b0, 1'b0, 32'h0, 5'd5, kCTRL_RW); cycle();
        drive(1'b1, 32'hB, 1'b0, 1'b0, 1'b0, 32'h0, 5'd6, kCTRL_RW); cycle();
        chk("bp_hold_A", out_alu_out, 32'hA);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        idle();
        out_ready = 1'b1;
        cycle();
        chk("bp_then_B", out_alu_out, 32'hB);
        chk("bp_B_valid", 32'(out_valid), 32'd1);
        cycle();
        chk("bp_empty", 32'(out_valid), 32'd0);

        // Taken branch then wrong-path entry
        drive(1'b1, 32'h55, 1'b1, 1'b1, 1'b0, 32'h0000_0100, 5'd0, 4'd0); cycle();
        chk("br_redirect", 32'(redirect_valid), 32'd1);
        chk("br_pc", redirect_pc, 32'h100);
        chk("br_entry", out_alu_out, 32'h55);
        drive(1'b1, 32'hDEAD, 1'b0, 1'b0, 1'b0, 32'h0, 5'd7, kCTRL_RW); cycle();
        chk("br_pulse_end", 32'(redirect_valid), 32'd0);
        chk("br_squashed", 32'(out_valid), 32'd0);

        // Not-taken branch, then JAL
        drive(1'b1, 32'h66, 1'b1, 1'b0, 1'b0, 32'h200, 5'd0, 4'd0); cycle();
        chk("nt_no_redirect", 32'(redirect_valid), 32'd0);
        drive(1'b1, 32'h44, 1'b0, 1'b0, 1'b1, 32'h300, 5'd1, kCTRL_RW); cycle();
        chk("jal_redirect", 32'(redirect_valid), 32'd1);
        chk("jal_pc", redirect_pc, 32'h300);
        chk("jal_rd", 32'(out_rd), 32'd1);
        chk("jal_alu", out_alu_out, 32'h44);
        idle(); cycle();

        // Flush with a taken branch in the same cycle
        out_ready = 1'b0;
        drive(1'b1, 32'h1, 1'b0, 1'b0, 1'b0, 32'h0, 5'd8, kCTRL_RW); cycle();
        drive(1'b1, 32'h2, 1'b0, 1'b0, 1'b0, 32'h0, 5'd9, kCTRL_RW); cycle();
        drive(1'b1, 32'h3, 1'b1, 1'b1, 1'b0, 32'h400, 5'd0, 4'd0);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        chk("fl_out_valid", 32'(out_valid), 32'd0);
        chk("fl_in_ready", 32'(in_ready), 32'd1);
        chk("fl_redirect", 32'(redirect_valid), 32'd0);
        idle(); cycle();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0, $urandom,
                  5'($urandom_range(0, 31)), 4'($urandom_range(0, 15)));
            out_ready = $urandom_range(0, 9) < 7;
            flush     = $urandom_range(0, 24) == 0;
            cycle();
        end
        flush = 1'b0;
        idle();
        out_ready = 1'b1;
        cycle(); cycle(); cycle();

        // Async reset while an entry and a redirect are live
        out_ready = 1'b0;
        drive(1'b1, 32'h77, 1'b0, 1'b0, 1'b1, 32'h500, 5'd1, kCTRL_RW); cycle();
        chk("ar_pre_valid", 32'(out_valid), 32'd1);
        chk("ar_pre_redirect", 32'(redirect_valid), 32'd1);
        idle();
        #2 reset = 1'b1;
        #1;
        chk("ar_out_valid", 32'(out_valid), 32'd0);
        chk("ar_redirect", 32'(redirect_valid), 32'd0);
        chk("ar_out_alu", out_alu_out, 32'd0);
        chk("ar_in_ready", 32'(in_ready), 32'd1);
        drive(1'b1, 32'h88, 1'b0, 1'b0, 1'b0, 32'h0, 5'd2, kCTRL_RW);
        repeat (2) @(negedge clk);
        chk("ar_hold_valid", 32'(out_valid), 32'd0);
        chk("ar_hold_alu", out_alu_out, 32'd0);
        chk("ar_hold_redirect", 32'(redirect_valid), 32'd0);
        idle();
        reset = 1'b0;
        q.delete();
        redir = 1'b0;
        cycle();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/ex_mem_skid_stage.md
Name: ex_mem_skid_stage

Overview:
- EX/MEM boundary stage, directly downstream of the ALU.
- Captures ALU result, branch decision, store data, destination register and memory/writeback control into a two-entry skid buffer.
- Uses a valid/ready handshake toward the memory stage.
- Raises a registered PC-redirect when an accepted entry is a taken branch or jump, and squashes the one wrong-path input arriving in the redirect cycle.

Parameters:
- DATA_WIDTH, 32, width of ALU result, store data and PC/target.
- RD_WIDTH, 5, destination register index width.
- CTRL_WIDTH, 4, control bundle width: {mem_to_reg, mem_write, mem_read, reg_write}.

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  EX entry present.
- in_ready  out  1  stage can accept an entry.
- in_alu_out  in  DATA_WIDTH  ALU result.
- in_branch_enable  in  1  ALU branch condition.
- in_is_branch  in  1  entry is a conditional branch.
- in_is_jump  in  1  entry is JAL/JALR (always redirects).
- in_branch_target  in  DATA_WIDTH  computed target address.
- in_store_data  in  DATA_WIDTH  rs2 value for stores.
- in_rd  in  RD_WIDTH  destination register.
- in_ctrl  in  CTRL_WIDTH  memory/writeback controls.
- flush  in  1  synchronous kill of all held state.
- out_valid  out  1  MEM entry present.
- out_ready  in  1  MEM stage consumes the entry.
- out_alu_out, out_store_data  out  DATA_WIDTH  registered payload.
- out_rd  out  RD_WIDTH  registered payload.
- out_ctrl  out  CTRL_WIDTH  registered payload.
- redirect_valid  out  1  one-cycle PC-redirect pulse.
- redirect_pc  out  DATA_WIDTH  redirect target.

Behaviour:
- Reset (async, active-high): out_valid=0, skid_valid=0, redirect_valid=0; all payload registers, redirect_pc and out_* = 0. in_ready=1 right after reset.
- in_ready = !skid_valid. It is a registered-state function and does not depend on out_ready combinationally.
- squash = redirect_valid.
- accept = in_valid & in_ready & !flush & !squash.
- drain = !out_valid | out_ready.
- Slot update each cycle, flush aside:
  - drain & skid_valid: out slot <= skid; skid_valid<=0; no accept possible, since in_ready=0.
  - drain & !skid_valid & accept: out slot <= input; out_valid<=1.
  - drain with nothing to load: out_valid<=0.
  - !drain & accept: skid <= input; skid_valid<=1. The out slot holds.
- Latency: 1 cycle from accept to out_valid.
- Throughput: 1 entry per cycle while out_ready=1.
- Stability: out payload is stable while out_valid & !out_ready.
- Redirect:
  - Triggered when accept and (in_is_jump | (in_is_branch & in_branch_enable)).
  - Next cycle: redirect_valid=1 for exactly one cycle, redirect_pc = in_branch_target.
  - The redirecting entry itself still enters the buffer normally, so JAL/JALR link writeback is kept.
  - A branch entry with reg_write=0 is still forwarded; MEM ignores it.
- Squash:
  - In the redirect_valid cycle, a handshake that would otherwise accept completes (in_valid & in_ready) but the entry is discarded.
  - A discarded entry never reaches the output and cannot trigger a redirect.
  - Back-to-back redirects are therefore impossible.
- Flush:
  - Dominates everything: next cycle out_valid=0, skid_valid=0, redirect_valid=0, with no accept.
  - Payload registers may hold stale data.
  - flush together with a redirect-causing input: no redirect.
- Simultaneous skid drain and in_valid: input stalls one cycle (in_ready=0), then is accepted.
- Reset asserted mid-operation: all entries and any pending redirect are lost immediately.

Decomposition:
- Shared header, alongside the existing sail-core defines:
  - ctrl bit index constants kSAIL_EXMEM_CTRL_REGWRITE/MEMREAD/MEMWRITE/MEMTOREG;
  - payload bundle width constant.
- One sub-module, ex_mem_entry_reg: a load-enabled, async-reset payload register with valid bit, instantiated twice (out slot, skid slot).

Test Plan:
- Streaming:
  - Stimulus: out_ready=1; three entries alu_out=0x11,0x22,0x33 on consecutive cycles.
  - Required: out_alu_out shows 0x11,0x22,0x33 one cycle after each; in_ready stays 1.
- Backpressure:
  - Stimulus: out_ready=0; send 0xA then 0xB.
  - Required: out holds 0xA; skid holds 0xB; in_ready=0 next cycle.
  - Then out_ready=1 for 2 cycles: outputs 0xA then 0xB with no loss or duplication.
- Taken branch:
  - Stimulus: in_is_branch=1, branch_enable=1, target=0x0000_0100, followed immediately by entry 0xDEAD.
  - Required: redirect_valid=1 for one cycle with redirect_pc=0x100; 0xDEAD never appears on out; the branch entry does appear.
- Not-taken branch and jump:
  - Not-taken branch (branch_enable=0): no redirect.
  - JAL (is_jump=1, rd=1, reg_write=1, alu_out=0x44): redirect, and out_rd=1 with out_alu_out=0x44.
- Flush:
  - Stimulus: fill both slots, then pulse flush with a taken-branch input in the same cycle.
  - Required: next cycle out_valid=0, in_ready=1, redirect_valid=0.
- Async reset:
  - Stimulus: assert reset between clock edges while out_valid=1 and a redirect is pending.
  - Required: out_valid=0 and redirect_valid=0 immediately, without a clock edge; outputs stay 0 until reset is released.
